// File: rtl/list_path_update.sv
// list_path_update: path-metric and partial-codeword update stage of an L=4
// SCL polar decoder, sitting downstream of the sorted-PM selector.
// Each accepted step either applies the sorted survivor list (information
// bit) or appends a frozen zero with per-path PMs. After N steps the
// minimum-PM path's codeword is presented on out_word/out_pm.
// Optional build macro: LIST_PATH_UPDATE_PM_NORM_EN (subtract the step
// minimum from all new PMs before storing them).
module list_path_update #(
  parameter int PM_WIDTH    = 8,
  parameter int INDEX_WIDTH = 3,
  parameter int L           = 4,
  parameter int N           = 64,
  parameter int CNT_WIDTH   = 6
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic                                  in_frozen,
  input  logic [(PM_WIDTH+INDEX_WIDTH)*L-1:0]   in_sorted,
  input  logic [L-1:0]                          in_hd,
  input  logic [PM_WIDTH*L-1:0]                 in_pm_frz,
  output logic [PM_WIDTH*L-1:0]                 pm_out,
  output logic [CNT_WIDTH-1:0]                  bit_idx,
  output logic                                  busy,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [N-1:0]                          out_word,
  output logic [PM_WIDTH-1:0]                   out_pm,
  output logic [1:0]                            state_dbg
);

  localparam int EW   = PM_WIDTH + INDEX_WIDTH;
  localparam int SELW = $clog2(L);
  localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(N - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FINAL = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  logic [1:0]             state;
  logic [1:0]             state_nxt;
  logic [PM_WIDTH-1:0]    pm_q [L];
  logic [N-1:0]           mem_q [L];
  logic [CNT_WIDTH-1:0]   bit_idx_q;
  logic [N-1:0]           out_word_q;
  logic [PM_WIDTH-1:0]    out_pm_q;

  logic [INDEX_WIDTH-1:0] surv_idx [L];
  logic [PM_WIDTH-1:0]    surv_pm  [L];
  logic [PM_WIDTH-1:0]    frz_pm   [L];
  logic [INDEX_WIDTH-2:0] parent   [L];
  logic [PM_WIDTH-1:0]    raw_pm   [L];
  logic [PM_WIDTH-1:0]    new_pm   [L];
  logic [N-1:0]           new_mem  [L];

  logic [SELW-1:0]        best_sel;
  logic [PM_WIDTH-1:0]    best_pm;

  logic                   accept;
  logic                   last_step;

  // Handshakes: a step transfers on a rising clk edge where in_valid and
  // in_ready are both high; the word transfers on an edge where out_valid
  // and out_ready are both high. Valid never depends on ready. A start
  // pulse pre-empts a step offered in the same cycle.
  assign in_ready  = (state == S_RUN) & ~start;
  assign accept    = in_valid & in_ready;
  assign last_step = accept & (bit_idx_q == LAST_BIT);

  assign bit_idx   = bit_idx_q;
  assign busy      = (state == S_RUN) | (state == S_FINAL);
  assign out_valid = (state == S_OUT);
  assign out_word  = out_word_q;
  assign out_pm    = out_pm_q;
  assign state_dbg = state;

  // Split the packed input buses into per-survivor / per-path fields (MS = 0).
  always_comb begin
    for (int j = 0; j < L; j++) begin
      surv_idx[j] = in_sorted[(L-1-j)*EW + PM_WIDTH +: INDEX_WIDTH];
      surv_pm[j]  = in_sorted[(L-1-j)*EW +: PM_WIDTH];
      frz_pm[j]   = in_pm_frz[(L-1-j)*PM_WIDTH +: PM_WIDTH];
    end
  end

`ifdef LIST_PATH_UPDATE_PM_NORM_EN
  logic [PM_WIDTH-1:0] frz_min;
  logic [PM_WIDTH-1:0] step_min;

  // Smallest frozen-step PM; information steps use survivor 0 (list is ascending).
  always_comb begin
    frz_min = frz_pm[0];
    for (int l = 1; l < L; l++) begin
      if (frz_pm[l] < frz_min) frz_min = frz_pm[l];
    end
    step_min = in_frozen ? frz_min : surv_pm[0];
  end
`endif

  // New PM per slot: survivor PM or frozen PM, optionally normalised to the step minimum.
  always_comb begin
    for (int j = 0; j < L; j++) begin
      raw_pm[j] = in_frozen ? frz_pm[j] : surv_pm[j];
`ifdef LIST_PATH_UPDATE_PM_NORM_EN
      new_pm[j] = raw_pm[j] - step_min;
`else
      new_pm[j] = raw_pm[j];
`endif
    end
  end

  // New path memory per slot: copy the parent (or keep own path when frozen)
  // and write the decided bit at bit_idx. Reads use the pre-edge memories.
  always_comb begin
    for (int j = 0; j < L; j++) begin
      parent[j]  = surv_idx[j][INDEX_WIDTH-1:1];
      new_mem[j] = in_frozen ? mem_q[j] : mem_q[parent[j]];
      new_mem[j][bit_idx_q] = in_frozen ? 1'b0 : (in_hd[parent[j]] ^ surv_idx[j][0]);
    end
  end

  // Minimum-PM path; strict compare keeps the lowest index on ties.
  always_comb begin
    best_sel = '0;
    best_pm  = pm_q[0];
    for (int l = 1; l < L; l++) begin
      if (pm_q[l] < best_pm) begin
        best_pm  = pm_q[l];
        best_sel = SELW'(l);
      end
    end
  end

  // Flatten the PM registers onto pm_out (MS field = path 0).
  always_comb begin
    pm_out = '0;
    for (int l = 0; l < L; l++) begin
      pm_out[(L-1-l)*PM_WIDTH +: PM_WIDTH] = pm_q[l];
    end
  end

  // Next-state logic; start restarts the codeword from any state.
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = S_RUN;
    end else begin
      case (state)
        S_IDLE:  state_nxt = S_IDLE;
        S_RUN:   if (last_step) state_nxt = S_FINAL;
        S_FINAL: state_nxt = S_OUT;
        S_OUT:   if (out_ready) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // PM registers, path memories and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < L; l++) begin
        pm_q[l]  <= '0;
        mem_q[l] <= '0;
      end
      bit_idx_q <= '0;
    end else if (start) begin
      for (int l = 0; l < L; l++) begin
        pm_q[l]  <= '0;
        mem_q[l] <= '0;
      end
      bit_idx_q <= '0;
    end else if (accept) begin
      for (int l = 0; l < L; l++) begin
        pm_q[l]  <= new_pm[l];
        mem_q[l] <= new_mem[l];
      end
      bit_idx_q <= last_step ? '0 : bit_idx_q + CNT_WIDTH'(1);
    end
  end

  // Capture the best path's word and PM during FINAL; held through OUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_word_q <= '0;
      out_pm_q   <= '0;
    end else if ((state == S_FINAL) && !start) begin
      out_word_q <= mem_q[best_sel];
      out_pm_q   <= best_pm;
    end
  end

endmodule

// File: tb/tb_list_path_update.sv
// Self-checking bench for list_path_update: directed steps with literal
// expectations plus a behavioural model compared every cycle.
module tb_list_path_update;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic        in_frozen;
  logic [43:0] in_sorted;
  logic [3:0]  in_hd;
  logic [31:0] in_pm_frz;
  logic [31:0] pm_out;
  logic [5:0]  bit_idx;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_word;
  logic [7:0]  out_pm;
  logic [1:0]  state_dbg;

  int checks   = 0;
  int failures = 0;

  list_path_update dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_frozen(in_frozen), .in_sorted(in_sorted),
    .in_hd(in_hd), .in_pm_frz(in_pm_frz), .pm_out(pm_out), .bit_idx(bit_idx),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_pm(out_pm), .state_dbg(state_dbg)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 collecting steps, 2 choosing best, 3 presenting word
  int          m_phase = 0;
  int          m_bit   = 0;
  logic [7:0]  m_pm  [4] = '{default: 8'd0};
  logic [63:0] m_mem [4] = '{default: 64'd0};
  logic [63:0] m_word = 64'd0;
  logic [7:0]  m_opm  = 8'd0;

  task automatic model_clear();
    for (int l = 0; l < 4; l++) begin
      m_pm[l]  = 8'd0;
      m_mem[l] = 64'd0;
    end
    m_bit = 0;
  endtask

  task automatic model_step();
    logic [7:0]  npm  [4];
    logic [63:0] nmem [4];
    logic [7:0]  mn;
    int k, p;
    for (int j = 0; j < 4; j++) begin
      if (in_frozen) begin
        npm[j]  = in_pm_frz[(3-j)*8 +: 8];
        nmem[j] = m_mem[j];
        nmem[j][m_bit] = 1'b0;
      end else begin
        k = int'(in_sorted[(3-j)*11+8 +: 3]);
        p = k / 2;
        npm[j]  = in_sorted[(3-j)*11 +: 8];
        nmem[j] = m_mem[p];
        nmem[j][m_bit] = (k % 2 == 1) ? ~in_hd[p] : in_hd[p];
      end
    end
`ifdef LIST_PATH_UPDATE_PM_NORM_EN
    mn = npm[0];
    if (in_frozen) begin
      for (int j = 1; j < 4; j++) if (npm[j] < mn) mn = npm[j];
    end
`else
    mn = 8'd0;
`endif
    for (int j = 0; j < 4; j++) begin
      m_pm[j]  = npm[j] - mn;
      m_mem[j] = nmem[j];
    end
    m_bit++;
    if (m_bit == 64) begin
      m_bit   = 0;
      m_phase = 2;
    end
  endtask

  task automatic model_pick();
    int b = 0;
    for (int l = 1; l < 4; l++) if (m_pm[l] < m_pm[b]) b = l;
    m_word = m_mem[b];
    m_opm  = m_pm[b];
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_clear();
        m_phase = 0;
        m_word  = 64'd0;
        m_opm   = 8'd0;
      end else if (start) begin
        model_clear();
        m_phase = 1;
      end else begin
        case (m_phase)
          1: if (in_valid) model_step();
          2: begin model_pick(); m_phase = 3; end
          3: if (out_ready) m_phase = 0;
          default: ;
        endcase
      end
    end
  end

  // scoreboard compare on every falling edge
  initial begin
    forever begin
      @(negedge clk);
      check("pm_out",    pm_out,    {m_pm[0], m_pm[1], m_pm[2], m_pm[3]});
      check("bit_idx",   bit_idx,   64'(m_bit));
      check("busy",      busy,      (m_phase == 1) || (m_phase == 2));
      check("in_ready",  in_ready,  (m_phase == 1) && !start);
      check("out_valid", out_valid, m_phase == 3);
      check("out_word",  out_word,  m_word);
      check("out_pm",    out_pm,    m_opm);
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [43:0] mk_sorted(input logic [2:0] i0, input logic [7:0] p0,
                                            input logic [2:0] i1, input logic [7:0] p1,
                                            input logic [2:0] i2, input logic [7:0] p2,
                                            input logic [2:0] i3, input logic [7:0] p3);
    return {i0, p0, i1, p1, i2, p2, i3, p3};
  endfunction

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offer one step and return at 1 time unit after the accepting edge.
  task automatic do_step(input logic frz, input logic [43:0] srt, input logic [3:0] hd,
                         input logic [31:0] pf);
    logic acc = 1'b0;
    in_frozen = frz;
    in_sorted = srt;
    in_hd     = hd;
    in_pm_frz = pf;
    in_valid  = 1'b1;
    for (int c = 0; c < 8 && !acc; c++) begin
      #1;
      acc = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("step_accepted", acc, 1'b1);
  endtask

  task automatic frozen_steps(input int n, input logic [31:0] pf);
    for (int i = 0; i < n; i++) do_step(1'b1, 44'd0, 4'd0, pf);
  endtask

  logic [2:0] r_i [4];
  logic [7:0] r_p [4];
  logic       ov;

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_frozen = 1'b0;
    in_sorted = '0; in_hd = '0; in_pm_frz = '0; out_ready = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("rst_pm_out", pm_out, 64'd0);
    check("rst_state_idle", state_dbg, 64'd0);
    check("rst_in_ready", in_ready, 64'd0);
    #1 rst_n = 1'b1;

    // 64 frozen steps {3,5,7,9}
    pulse_start();
    frozen_steps(64, {8'd3, 8'd5, 8'd7, 8'd9});
    @(negedge clk);
    check("frz_final_no_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("frz_out_valid", out_valid, 1'b1);
    check("frz_out_word", out_word, 64'd0);
`ifdef LIST_PATH_UPDATE_PM_NORM_EN
    check("frz_out_pm", out_pm, 64'd0);
`else
    check("frz_out_pm", out_pm, 64'd3);
`endif
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("frz_hold_valid", out_valid, 1'b1);
      check("frz_hold_word", out_word, 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("frz_drained", out_valid, 1'b0);

    // information steps
    pulse_start();
    do_step(1'b0, mk_sorted(3'd0, 8'd12, 3'd1, 8'd15, 3'd2, 8'd20, 3'd4, 8'd40), 4'b0000, 32'd0);
    @(negedge clk);
`ifdef LIST_PATH_UPDATE_PM_NORM_EN
    check("info1_pm", pm_out, {8'd0, 8'd3, 8'd8, 8'd28});
`else
    check("info1_pm", pm_out, {8'd12, 8'd15, 8'd20, 8'd40});
`endif
    do_step(1'b0, mk_sorted(3'd3, 8'd5, 3'd2, 8'd6, 3'd3, 8'd7, 3'd2, 8'd8), 4'b0010, 32'd0);
    @(negedge clk);
`ifdef LIST_PATH_UPDATE_PM_NORM_EN
    check("info2_pm", pm_out, {8'd0, 8'd1, 8'd2, 8'd3});
`else
    check("info2_pm", pm_out, {8'd5, 8'd6, 8'd7, 8'd8});
`endif
    check("info2_bit_idx", bit_idx, 64'd2);
    // paths now hold bits[1:0] = {01,11,01,11}; path 1 ties path 2 and wins
    frozen_steps(62, {8'd9, 8'd8, 8'd8, 8'd10});
    @(posedge clk); #1;
    @(negedge clk);
    check("info_out_valid", out_valid, 1'b1);
    check("info_out_word", out_word, 64'h3);
`ifdef LIST_PATH_UPDATE_PM_NORM_EN
    check("info_out_pm", out_pm, 64'd0);
`else
    check("info_out_pm", out_pm, 64'd8);
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // start collides with a step at bit_idx 30
    pulse_start();
    frozen_steps(30, {8'd1, 8'd2, 8'd3, 8'd4});
    start = 1'b1; in_valid = 1'b1; in_frozen = 1'b1;
    #1 check("collide_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("collide_bit_idx", bit_idx, 64'd0);
    check("collide_pm", pm_out, 64'd0);
    check("collide_busy", busy, 1'b1);

    // random full codeword with gaps and output stall
    for (int b = 0; b < 64; b++) begin
      r_p[0] = 8'($urandom_range(0, 50));
      for (int j = 0; j < 4; j++) r_i[j] = 3'($urandom_range(0, 7));
      for (int j = 1; j < 4; j++) r_p[j] = r_p[j-1] + 8'($urandom_range(0, 20));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      do_step(1'($urandom_range(0, 1)),
              mk_sorted(r_i[0], r_p[0], r_i[1], r_p[1], r_i[2], r_p[2], r_i[3], r_p[3]),
              4'($urandom_range(0, 15)), 32'($urandom));
    end
    ov = 1'b0;
    for (int c = 0; c < 10 && !ov; c++) begin
      @(negedge clk);
      ov = out_valid;
    end
    check("rand_out_valid", ov, 1'b1);
    repeat ($urandom_range(0, 3)) @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // asynchronous reset mid-codeword at bit_idx 10
    pulse_start();
    frozen_steps(10, {8'd7, 8'd6, 8'd5, 8'd4});
    check("pre_rst_bit_idx", bit_idx, 64'd10);
    rst_n = 1'b0;
    #1;
    check("arst_pm_out", pm_out, 64'd0);
    check("arst_bit_idx", bit_idx, 64'd0);
    check("arst_busy", busy, 1'b0);
    check("arst_in_ready", in_ready, 1'b0);
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_out_word", out_word, 64'd0);
    check("arst_state_idle", state_dbg, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // run-time bound
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
